// File: rtl/avalon_st_pkg.sv
// Shared types and sizing helpers for the Avalon-ST FIFO slice.
package avalon_st_pkg;

    localparam int unsigned BEAT_BYTES = 16;
    localparam int unsigned DATA_WIDTH = 8 * BEAT_BYTES;

    function automatic int unsigned empty_width(input int unsigned bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned EMPTY_WIDTH = empty_width(BEAT_BYTES);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic                   sop;
        logic                   eop;
        logic [EMPTY_WIDTH-1:0] empty;
    } avalon_beat_t;

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST stream bundle; master drives the beat, slave drives rdy.
interface avalon_st_if
    import avalon_st_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_IN_BYTES = 16
);
    logic [8*DATA_WIDTH_IN_BYTES-1:0]               data;
    logic                                           valid;
    logic                                           sop;
    logic                                           eop;
    logic [empty_width(DATA_WIDTH_IN_BYTES)-1:0]    empty;
    logic                                           rdy;

    modport master (output data, valid, sop, eop, empty, input rdy);
    modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port beat storage: synchronous write, asynchronous read.
module fifo_mem
    import avalon_st_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  avalon_beat_t          wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output avalon_beat_t          rdata
);
    avalon_beat_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/avalon_st_fifo.sv
// First-word-fall-through Avalon-ST beat FIFO with fill level and packet-tail count.
module avalon_st_fifo
    import avalon_st_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_IN_BYTES = 16,
    parameter int unsigned DEPTH               = 16,
    parameter int unsigned ALMOST_FULL_THRESH  = DEPTH - 4
) (
    input  logic                        clk,
    input  logic                        rst,
    avalon_st_if.slave                  sink,
    avalon_st_if.master                 src,
    output logic [ptr_width(DEPTH)-1:0] fill_level,
    output logic [ptr_width(DEPTH)-1:0] pkt_count,
    output logic                        almost_full
);
    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned AW = PW - 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] pkt_count_q, pkt_count_d;
    logic [PW-1:0] fill_d;
    logic          rdy_q, rdy_d;
    logic          fifo_empty, full, push, pop;
    avalon_beat_t  wr_beat, head, last_q, out_beat;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = sink.valid && rdy_q && !full;
    assign pop        = !fifo_empty && src.rdy;

    assign wr_beat.data  = DATA_WIDTH'(sink.data);
    assign wr_beat.sop   = sink.sop;
    assign wr_beat.eop   = sink.eop;
    assign wr_beat.empty = EMPTY_WIDTH'(sink.empty);

    fifo_mem #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (wr_beat),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (head)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q + PW'(push);
        rd_ptr_d    = rd_ptr_q + PW'(pop);
        pkt_count_d = pkt_count_q + PW'(push && sink.eop) - PW'(pop && head.eop);
        fill_d      = wr_ptr_d - rd_ptr_d;
        rdy_d       = (fill_d != PW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pkt_count_q <= '0;
            rdy_q       <= 1'b0;
            last_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_count_q <= pkt_count_d;
            rdy_q       <= rdy_d;
            if (pop) begin
                last_q <= head;
            end
        end
    end

    // While empty, present the last popped beat so the outputs hold instead of showing stale RAM.
    assign out_beat = fifo_empty ? last_q : head;

    assign sink.rdy    = rdy_q;
    assign src.valid   = !fifo_empty;
    assign src.data    = out_beat.data[8*DATA_WIDTH_IN_BYTES-1:0];
    assign src.sop     = out_beat.sop;
    assign src.eop     = out_beat.eop;
    assign src.empty   = out_beat.empty;
    assign fill_level  = wr_ptr_q - rd_ptr_q;
    assign pkt_count   = pkt_count_q;
    assign almost_full = (fill_level >= PW'(ALMOST_FULL_THRESH));
endmodule

// File: tb/tb_avalon_st_fifo.sv
// Randomized bench for avalon_st_fifo against a queue-based reference model.
module tb_avalon_st_fifo;
    import avalon_st_pkg::*;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned THRESH = DEPTH - 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] fill_level, pkt_count;
    logic       almost_full;

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) sink_if ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) src_if ();

    avalon_st_fifo #(
        .DATA_WIDTH_IN_BYTES (16),
        .DEPTH               (DEPTH),
        .ALMOST_FULL_THRESH  (THRESH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sink        (sink_if),
        .src         (src_if),
        .fill_level  (fill_level),
        .pkt_count   (pkt_count),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    avalon_beat_t q[$];
    avalon_beat_t last_pop;
    logic         m_rdy;
    logic         m_push, m_pop;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eop_count();
        int n = 0;
        foreach (q[i]) if (q[i].eop) n++;
        return n;
    endfunction

    task automatic check_outputs();
        avalon_beat_t exp;
        exp = (q.size() != 0) ? q[0] : last_pop;
        check("src_valid",   src_if.valid, q.size() != 0);
        check("src_data",    src_if.data,  exp.data);
        check("src_sop",     src_if.sop,   exp.sop);
        check("src_eop",     src_if.eop,   exp.eop);
        check("src_empty",   src_if.empty, exp.empty);
        check("fill_level",  fill_level,   q.size());
        check("pkt_count",   pkt_count,    eop_count());
        check("almost_full", almost_full,  q.size() >= THRESH);
        check("sink_rdy",    sink_if.rdy,  m_rdy);
    endtask

    task automatic drive(input logic v, input logic [127:0] d, input logic s, input logic e,
                         input logic [3:0] em);
        sink_if.valid = v;
        sink_if.data  = d;
        sink_if.sop   = s;
        sink_if.eop   = e;
        sink_if.empty = em;
    endtask

    // One clock: update the model with what the edge should accept, then check at negedge.
    task automatic tick();
        avalon_beat_t b;
        @(posedge clk);
        m_push = sink_if.valid && m_rdy;
        m_pop  = (q.size() != 0) && src_if.rdy;
        b.data  = sink_if.data;
        b.sop   = sink_if.sop;
        b.eop   = sink_if.eop;
        b.empty = sink_if.empty;
        if (m_pop) last_pop = q.pop_front();
        if (m_push) q.push_back(b);
        m_rdy = (q.size() != DEPTH);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drain(input int budget);
        int c = 0;
        sink_if.valid = 1'b0;
        src_if.rdy    = 1'b1;
        while (q.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        check("drain_done", q.size() == 0, 1'b1);
    endtask

    initial begin
        logic [127:0] rep34;
        int           idx, next_exp, cyc, pushes;

        last_pop = '0;
        m_rdy    = 1'b0;
        src_if.rdy = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 16; i++) rep34[8*i +: 8] = 8'd34;

        // 1: reset then pass-through
        #1 check_outputs();
        #19;
        @(negedge clk);
        rst = 1'b1;
        src_if.rdy = 1'b1;
        tick();
        drive(1'b1, rep34, 1'b1, 1'b0, 4'd0); tick();
        drive(1'b1, rep34, 1'b0, 1'b0, 4'd0); tick();
        drive(1'b1, rep34, 1'b0, 1'b1, 4'd1); tick();
        drive(1'b0, '0, 1'b0, 1'b0, 4'd0);    tick();
        check("t1_pkt_end", pkt_count, 5'd0);

        // 2: fill to full with single-beat packets
        src_if.rdy = 1'b0;
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1,
                  4'($urandom_range(0, 15)));
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 4'd0);
        check("t2_full_fill", fill_level, 5'd16);
        check("t2_full_pkt",  pkt_count,  5'd16);
        check("t2_full_rdy",  sink_if.rdy, 1'b0);

        // 3: drain with alternating backpressure
        for (int i = 0; i < 40 && q.size() != 0; i++) begin
            src_if.rdy = (i % 2 == 0);
            tick();
        end
        check("t3_empty", fill_level, 5'd0);

        // 4: steady push/pop at fill level 5
        src_if.rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 128'(i + 100), i == 0, i == 4, 4'd0);
            tick();
        end
        src_if.rdy = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 128'(i + 200), 1'b0, (i == 4) || (i == 9), 4'($urandom_range(0, 15)));
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 4'd0);
        src_if.rdy = 1'b0;
        check("t4_fill", fill_level, 5'd5);
        drain(20);

        // 5: pointer wrap with random backpressure
        idx = 0; next_exp = 0; cyc = 0;
        while (next_exp < 40 && cyc < 600) begin
            drive(idx < 40, 128'(idx), 1'b0, 1'b0, 4'd0);
            src_if.rdy = 1'($urandom_range(0, 1));
            if (src_if.valid && src_if.rdy) begin
                check("t5_seq", src_if.data, 128'(next_exp));
                next_exp++;
            end
            tick();
            if (m_push) idx++;
            cyc++;
        end
        check("t5_count", 128'(next_exp), 128'd40);
        drive(1'b0, '0, 1'b0, 1'b0, 4'd0);
        drain(20);

        // 6: reset mid-packet
        src_if.rdy = 1'b0;
        pushes = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 128'(i + 7), i == 0, 1'b0, 4'd0);
            tick();
            if (m_push) pushes++;
        end
        check("t6_pushed", 128'(pushes), 128'd3);
        drive(1'b0, '0, 1'b0, 1'b0, 4'd0);
        rst = 1'b0;
        q.delete();
        last_pop = '0;
        m_rdy = 1'b0;
        #1;
        check("t6_valid_async", src_if.valid, 1'b0);
        check("t6_fill_async",  fill_level, 5'd0);
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        tick();
        src_if.rdy = 1'b1;
        drive(1'b1, 128'hABCD, 1'b1, 1'b1, 4'd3);
        tick();
        check("t6_new_valid", src_if.valid, 1'b1);
        check("t6_new_data",  src_if.data, 128'hABCD);
        drive(1'b0, '0, 1'b0, 1'b0, 4'd0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
